// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing a dual-port register memory between N_REQ requesters.
// Optional address bounds checking is enabled by defining MEM_ARB_BOUNDS_EN.
module mem_port_arbiter #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned MEM_SIZE  = 6,
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned ADDR_SIZE = $clog2(MEM_SIZE),
    parameter int unsigned ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              wr_valid,
    input  logic [N_REQ*ADDR_SIZE-1:0]    wr_addr,
    input  logic [N_REQ*DATA_W-1:0]       wr_data,
    output logic [N_REQ-1:0]              wr_ready,
    input  logic [N_REQ-1:0]              rd_valid,
    input  logic [N_REQ*ADDR_SIZE-1:0]    rd_addr,
    output logic [N_REQ-1:0]              rd_ready,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_err,
    output logic                          mem_write_flag,
    output logic [ADDR_SIZE-1:0]          mem_addr_w,
    output logic [DATA_W-1:0]             mem_data_in,
    output logic                          mem_read_flag,
    output logic [ADDR_SIZE-1:0]          mem_addr_r,
    input  logic [DATA_W-1:0]             mem_data_out
);

    // Returns {hit, index}: first set bit of v at or above ptr, else lowest set bit.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] v,
                                              input logic [ID_W-1:0]  ptr);
        logic            found_hi;
        logic            found_any;
        logic [ID_W-1:0] sel_hi;
        logic [ID_W-1:0] sel_any;
        found_hi  = 1'b0;
        found_any = 1'b0;
        sel_hi    = '0;
        sel_any   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                found_any = 1'b1;
                sel_any   = ID_W'(i);
                if (ID_W'(i) >= ptr) begin
                    found_hi = 1'b1;
                    sel_hi   = ID_W'(i);
                end
            end
        end
        return found_hi ? {1'b1, sel_hi} : {found_any, sel_any};
    endfunction

    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] g);
        return ((32'(g) + 32'd1) >= N_REQ) ? '0 : ID_W'(32'(g) + 32'd1);
    endfunction

    logic [ID_W-1:0]      wr_ptr;
    logic [ID_W-1:0]      rd_ptr;
    logic [ID_W:0]        wr_pick_c;
    logic [ID_W:0]        rd_pick_c;
    logic                 wr_hit_c;
    logic                 rd_hit_c;
    logic [ID_W-1:0]      wr_sel_c;
    logic [ID_W-1:0]      rd_sel_c;
    logic [ADDR_SIZE-1:0] wr_addr_sel_c;
    logic [ADDR_SIZE-1:0] rd_addr_sel_c;
    logic [DATA_W-1:0]    wr_data_sel_c;
    logic                 wr_in_range_c;
    logic                 rd_in_range_c;

    // Grant selection, slice muxing and memory drive; reset masks every grant.
    always_comb begin
        wr_pick_c     = rr_pick(wr_valid, wr_ptr);
        rd_pick_c     = rr_pick(rd_valid, rd_ptr);
        wr_hit_c      = wr_pick_c[ID_W] & rst_n;
        rd_hit_c      = rd_pick_c[ID_W] & rst_n;
        wr_sel_c      = wr_pick_c[ID_W-1:0];
        rd_sel_c      = rd_pick_c[ID_W-1:0];
        wr_addr_sel_c = '0;
        rd_addr_sel_c = '0;
        wr_data_sel_c = '0;
        wr_ready      = '0;
        rd_ready      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == wr_sel_c) begin
                wr_addr_sel_c = wr_addr[i*ADDR_SIZE +: ADDR_SIZE];
                wr_data_sel_c = wr_data[i*DATA_W +: DATA_W];
            end
            if (ID_W'(i) == rd_sel_c) begin
                rd_addr_sel_c = rd_addr[i*ADDR_SIZE +: ADDR_SIZE];
            end
            wr_ready[i] = wr_hit_c && (ID_W'(i) == wr_sel_c);
            rd_ready[i] = rd_hit_c && (ID_W'(i) == rd_sel_c);
        end
`ifdef MEM_ARB_BOUNDS_EN
        wr_in_range_c = (32'(wr_addr_sel_c) < MEM_SIZE);
        rd_in_range_c = (32'(rd_addr_sel_c) < MEM_SIZE);
`else
        wr_in_range_c = 1'b1;
        rd_in_range_c = 1'b1;
`endif
        mem_write_flag = wr_hit_c & wr_in_range_c;
        mem_addr_w     = mem_write_flag ? wr_addr_sel_c : '0;
        mem_data_in    = mem_write_flag ? wr_data_sel_c : '0;
        mem_read_flag  = rd_hit_c & rd_in_range_c;
        mem_addr_r     = mem_read_flag ? rd_addr_sel_c : '0;
    end

`ifdef MEM_ARB_BOUNDS_EN
    logic rsp_err_q;
`endif

    // Pointers and the response tag that lines up with the memory's read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
`ifdef MEM_ARB_BOUNDS_EN
            rsp_err_q <= 1'b0;
`endif
        end else begin
            if (wr_hit_c) begin
                wr_ptr <= rr_next(wr_sel_c);
            end
            if (rd_hit_c) begin
                rd_ptr <= rr_next(rd_sel_c);
                rsp_id <= rd_sel_c;
            end
            rsp_valid <= rd_hit_c;
`ifdef MEM_ARB_BOUNDS_EN
            rsp_err_q <= rd_hit_c & ~rd_in_range_c;
`endif
        end
    end

`ifdef MEM_ARB_BOUNDS_EN
    assign rsp_err  = rsp_err_q;
    assign rsp_data = rsp_err_q ? '0 : mem_data_out;
`else
    assign rsp_err  = 1'b0;
    assign rsp_data = mem_data_out;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and a response scoreboard.
module tb_mem_port_arbiter;
    localparam int unsigned N_REQ     = 2;
    localparam int unsigned MEM_SIZE  = 6;
    localparam int unsigned DATA_W    = 10;
    localparam int unsigned ADDR_SIZE = 3;
    localparam int unsigned ID_W      = 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    logic                       clk;
    logic                       rst_n;
    logic [N_REQ-1:0]           wr_valid;
    logic [N_REQ*ADDR_SIZE-1:0] wr_addr;
    logic [N_REQ*DATA_W-1:0]    wr_data;
    logic [N_REQ-1:0]           wr_ready;
    logic [N_REQ-1:0]           rd_valid;
    logic [N_REQ*ADDR_SIZE-1:0] rd_addr;
    logic [N_REQ-1:0]           rd_ready;
    logic                       rsp_valid;
    logic [ID_W-1:0]            rsp_id;
    logic [DATA_W-1:0]          rsp_data;
    logic                       rsp_err;
    logic                       mem_write_flag;
    logic [ADDR_SIZE-1:0]       mem_addr_w;
    logic [DATA_W-1:0]          mem_data_in;
    logic                       mem_read_flag;
    logic [ADDR_SIZE-1:0]       mem_addr_r;
    logic [DATA_W-1:0]          mem_data_out;

    int   checks;
    int   errors;
    int   rsp_seen;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [DATA_W-1:0] mem [MEM_SIZE];

    mem_port_arbiter #(
        .N_REQ(N_REQ), .MEM_SIZE(MEM_SIZE), .DATA_W(DATA_W),
        .ADDR_SIZE(ADDR_SIZE), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_write_flag(mem_write_flag), .mem_addr_w(mem_addr_w), .mem_data_in(mem_data_in),
        .mem_read_flag(mem_read_flag), .mem_addr_r(mem_addr_r), .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port register memory: registered read returns pre-write contents.
    always @(posedge clk) begin
        if (mem_write_flag && (32'(mem_addr_w) < MEM_SIZE)) mem[mem_addr_w] <= mem_data_in;
        if (mem_read_flag && (32'(mem_addr_r) < MEM_SIZE)) mem_data_out <= mem[mem_addr_r];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data, input logic err);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d data=0x%0h expected no response",
                         rsp_id, rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
        end
    end

    logic [1:0] t2_rdy [4];
    logic [2:0] t2_adr [4];
    logic [1:0] t5_rdy [4];

    initial begin
        checks = 0; errors = 0; rsp_seen = 0;
        for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = '0;
        mem_data_out = '0;
        t2_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
        t2_adr = '{3'd1, 3'd2, 3'd1, 3'd2};
        t5_rdy = '{2'b10, 2'b01, 2'b10, 2'b01};
        wr_valid = '0; wr_addr = '0; wr_data = '0;
        rd_addr = '0;

        // 1: reset with read traffic pending, then a reset in the middle of traffic
        rst_n = 1'b0; rd_valid = 2'b11;
        @(negedge clk);
        chk("rst_rd_ready", 32'(rd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_read_flag", 32'(mem_read_flag), 32'd0);
        next_cyc();
        rst_n = 1'b1; push(1'b0, 10'h000, 1'b0);
        @(negedge clk); chk("t1_first_grant", 32'(rd_ready), 32'h1);
        next_cyc(); push(1'b1, 10'h000, 1'b0);
        @(negedge clk); chk("t1_second_grant", 32'(rd_ready), 32'h2);
        next_cyc();
        @(negedge clk); chk("t1_third_grant", 32'(rd_ready), 32'h1);
        next_cyc(); rst_n = 1'b0;
        @(negedge clk);
        chk("t1_mid_rd_ready", 32'(rd_ready), 32'd0);
        chk("t1_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t1_mid_read_flag", 32'(mem_read_flag), 32'd0);
        next_cyc();
        @(negedge clk); chk("t1_mid_rd_ready2", 32'(rd_ready), 32'd0);
        next_cyc(); rst_n = 1'b1; push(1'b0, 10'h000, 1'b0);
        @(negedge clk); chk("t1_post_reset_grant", 32'(rd_ready), 32'h1);
        next_cyc(); rd_valid = 2'b00;

        // 2: write round-robin with both requesters held valid
        wr_valid = 2'b11; wr_addr = {3'd2, 3'd1}; wr_data = {10'h022, 10'h011};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_wr_ready", 32'(wr_ready), 32'(t2_rdy[k]));
            chk("t2_addr_w", 32'(mem_addr_w), 32'(t2_adr[k]));
            chk("t2_write_flag", 32'(mem_write_flag), 32'd1);
            next_cyc();
        end
        wr_valid = 2'b00;
        @(negedge clk);
        chk("t2_idle_flag", 32'(mem_write_flag), 32'd0);
        chk("t2_idle_addr", 32'(mem_addr_w), 32'd0);
        chk("t2_mem1", 32'(mem[1]), 32'h011);
        chk("t2_mem2", 32'(mem[2]), 32'h022);

        // 3: read latency
        next_cyc(); wr_valid = 2'b01; wr_addr = {3'd0, 3'd3}; wr_data = {10'h000, 10'h155};
        @(negedge clk);
        chk("t3_wr_ready", 32'(wr_ready), 32'h1);
        chk("t3_data_in", 32'(mem_data_in), 32'h155);
        next_cyc(); wr_valid = 2'b00; rd_valid = 2'b10; rd_addr = {3'd3, 3'd0};
        push(1'b1, 10'h155, 1'b0);
        @(negedge clk);
        chk("t3_rd_ready", 32'(rd_ready), 32'h2);
        chk("t3_addr_r", 32'(mem_addr_r), 32'd3);
        next_cyc(); rd_valid = 2'b00;
        @(negedge clk); chk("t3_latency", 32'(rsp_valid), 32'd1);
        next_cyc();
        @(negedge clk); chk("t3_single", 32'(rsp_valid), 32'd0);

        // 4: same-cycle write and read to one address
        next_cyc(); wr_valid = 2'b01; wr_addr = {3'd0, 3'd4}; wr_data = {10'h000, 10'h0AA};
        @(negedge clk); chk("t4_pre_wr", 32'(wr_ready), 32'h1);
        next_cyc(); wr_valid = 2'b10; wr_addr = {3'd4, 3'd0}; wr_data = {10'h3FF, 10'h000};
        rd_valid = 2'b01; rd_addr = {3'd0, 3'd4}; push(1'b0, 10'h0AA, 1'b0);
        @(negedge clk);
        chk("t4_wr_ready", 32'(wr_ready), 32'h2);
        chk("t4_rd_ready", 32'(rd_ready), 32'h1);
        next_cyc(); wr_valid = 2'b00; push(1'b0, 10'h3FF, 1'b0);
        @(negedge clk); chk("t4_rd_ready2", 32'(rd_ready), 32'h1);
        next_cyc(); rd_valid = 2'b00;

        // 5: back-to-back reads from two requesters
        wr_valid = 2'b11; wr_addr = {3'd5, 3'd0}; wr_data = {10'h200, 10'h001};
        @(negedge clk); chk("t5_wr0", 32'(wr_ready), 32'h1);
        next_cyc();
        @(negedge clk); chk("t5_wr1", 32'(wr_ready), 32'h2);
        next_cyc(); wr_valid = 2'b00; rd_valid = 2'b11; rd_addr = {3'd5, 3'd0};
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push(1'b1, 10'h200, 1'b0);
            else            push(1'b0, 10'h001, 1'b0);
            @(negedge clk);
            chk("t5_rd_ready", 32'(rd_ready), 32'(t5_rdy[k]));
            if (k > 0) chk("t5_rsp_continuous", 32'(rsp_valid), 32'd1);
            next_cyc();
        end
        rd_valid = 2'b00;

`ifdef MEM_ARB_BOUNDS_EN
        // 6: out-of-range write dropped, out-of-range read flagged
        wr_valid = 2'b01; wr_addr = {3'd0, 3'd6}; wr_data = {10'h000, 10'h123};
        rd_valid = 2'b10; rd_addr = {3'd6, 3'd0}; push(1'b1, 10'h000, 1'b1);
        @(negedge clk);
        chk("t6_wr_ready", 32'(wr_ready), 32'h1);
        chk("t6_write_flag", 32'(mem_write_flag), 32'd0);
        chk("t6_rd_ready", 32'(rd_ready), 32'h2);
        chk("t6_read_flag", 32'(mem_read_flag), 32'd0);
        next_cyc(); wr_valid = 2'b00; rd_valid = 2'b01; rd_addr = {3'd0, 3'd5};
        push(1'b0, 10'h200, 1'b0);
        @(negedge clk); chk("t6_rd_ready2", 32'(rd_ready), 32'h1);
        next_cyc(); rd_valid = 2'b00;
`endif

        repeat (3) next_cyc();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
`ifdef MEM_ARB_BOUNDS_EN
        chk("rsp_count", 32'(rsp_seen), 32'd12);
`else
        chk("rsp_count", 32'(rsp_seen), 32'd10);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
